// File: rtl/ring_pkg.sv
// Shared definitions for the ring code receive path.
//   ring_state_t : lock FSM states
//   RING_W       : native ring width of the partner counter
//   RING_INIT    : value the partner counter loads at its own reset
//   rotl1()      : one-step rotate-left of a RING_W-wide code
package ring_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } ring_state_t;

  localparam int                RING_W    = 8;
  localparam logic [RING_W-1:0] RING_INIT = 8'b1000_0000;

  function automatic logic [RING_W-1:0] rotl1(input logic [RING_W-1:0] v);
    return {v[RING_W-2:0], v[RING_W-1]};
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot decoder.
//   ring_in   in  WIDTH  candidate one-hot code
//   index     out IDX_W  position of the set bit (only meaningful when is_onehot)
//   is_onehot out 1      exactly one bit of ring_in is set
module onehot_to_bin #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ring_in,
  output logic [IDX_W-1:0] index,
  output logic             is_onehot
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt;

  // OR-ing the positions of set bits yields the exact position when only one
  // bit is set; for illegal codes the index is discarded by the caller.
  always_comb begin
    cnt   = '0;
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        cnt   = cnt + CNT_W'(1);
        index = index | IDX_W'(i);
      end
    end
  end

  assign is_onehot = (cnt == CNT_W'(1));

endmodule

// File: rtl/ring_code_decoder.sv
// Receive-side decoder for a rotate-left one-hot ring counter.
// Checks each sampled code for one-hot legality and rotate-left sequencing,
// decodes it to a binary index, tracks lock and counts errors (saturating).
//   clk        in  1      clock
//   init       in  1      synchronous active-high reset, dominates all inputs
//   ring_in    in  WIDTH  ring code
//   ring_vld   in  1      ring_in is sampled this cycle
//   index      out IDX_W  position of the set bit in the last legal code
//   index_vld  out 1      pulse: index updated from a legal sample
//   onehot_err out 1      pulse: sample was not one-hot
//   seq_err    out 1      pulse: one-hot but not rotl(prev,1)
//   wrap       out 1      pulse: in-sequence step from bit WIDTH-1 to bit 0
//   locked     out 1      level: FSM is LOCKED
//   err_count  out ERR_W  saturating count of error samples
module ring_code_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH    = RING_W,
  parameter int IDX_W    = $clog2(WIDTH),
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_vld,
  output logic [IDX_W-1:0] index,
  output logic             index_vld,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int GC_W = $clog2(LOCK_CNT + 1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  ring_state_t      state;
  logic [GC_W-1:0]  good_cnt;
  logic [WIDTH-1:0] prev;
  logic             prev_vld;

  logic [IDX_W-1:0] idx_p0;
  logic             onehot_p0;
  logic [WIDTH-1:0] rot_p0;
  logic             in_seq_p0;
  logic             seq_bad_p0;
  logic             wrap_p0;
  logic [GC_W-1:0]  good_nxt_p0;

  // ---- p0: combinational classification of the incoming sample ----
  onehot_to_bin #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_dec (
    .ring_in   (ring_in),
    .index     (idx_p0),
    .is_onehot (onehot_p0)
  );

  assign rot_p0      = {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign in_seq_p0   = prev_vld && onehot_p0 && (ring_in == rot_p0);
  // A legal code that does not follow prev, including an identical repeat.
  assign seq_bad_p0  = prev_vld && onehot_p0 && !in_seq_p0;
  assign wrap_p0     = in_seq_p0 && prev[WIDTH-1];
  assign good_nxt_p0 = good_cnt + GC_W'(1);

  // ---- p1: registered state, FSM and outputs ----
  always_ff @(posedge clk) begin
    if (init) begin
      state      <= UNLOCKED;
      good_cnt   <= '0;
      prev       <= '0;
      prev_vld   <= 1'b0;
      index      <= '0;
      index_vld  <= 1'b0;
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      wrap       <= 1'b0;
      locked     <= 1'b0;
      err_count  <= '0;
    end else begin
      index_vld  <= 1'b0;
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      wrap       <= 1'b0;

      if (ring_vld) begin
        if (onehot_p0) begin
          index     <= idx_p0;
          index_vld <= 1'b1;
          prev      <= ring_in;
          prev_vld  <= 1'b1;
          seq_err   <= seq_bad_p0;
          wrap      <= wrap_p0;
        end else begin
          onehot_err <= 1'b1;
        end

        if (!onehot_p0 || seq_bad_p0) begin
          err_count <= sat_inc(err_count);
        end

        case (state)
          UNLOCKED: begin
            if (onehot_p0) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
          end
          ACQUIRE: begin
            if (!onehot_p0) begin
              state    <= UNLOCKED;
              good_cnt <= '0;
            end else if (in_seq_p0) begin
              if (good_nxt_p0 == GC_W'(LOCK_CNT)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_nxt_p0;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!onehot_p0) begin
              state    <= UNLOCKED;
              locked   <= 1'b0;
              good_cnt <= '0;
            end else if (!in_seq_p0) begin
              state    <= ACQUIRE;
              locked   <= 1'b0;
              good_cnt <= '0;
            end
          end
          default: begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_code_decoder.sv
module tb_ring_code_decoder;
  import ring_pkg::*;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic [7:0] ring_in = '0;
  logic       ring_vld = 1'b0;

  logic [2:0] index_a, index_b;
  logic       index_vld_a, index_vld_b;
  logic       onehot_err_a, onehot_err_b;
  logic       seq_err_a, seq_err_b;
  logic       wrap_a, wrap_b;
  logic       locked_a, locked_b;
  logic [7:0] err_count_a;
  logic [1:0] err_count_b;

  always #5 clk = ~clk;

  ring_code_decoder #(.WIDTH(8), .IDX_W(3), .LOCK_CNT(4), .ERR_W(8)) dut_a (
    .clk(clk), .init(init), .ring_in(ring_in), .ring_vld(ring_vld),
    .index(index_a), .index_vld(index_vld_a), .onehot_err(onehot_err_a),
    .seq_err(seq_err_a), .wrap(wrap_a), .locked(locked_a), .err_count(err_count_a)
  );

  // Same stimulus, narrow error counter to exercise saturation.
  ring_code_decoder #(.WIDTH(8), .IDX_W(3), .LOCK_CNT(4), .ERR_W(2)) dut_b (
    .clk(clk), .init(init), .ring_in(ring_in), .ring_vld(ring_vld),
    .index(index_b), .index_vld(index_vld_b), .onehot_err(onehot_err_b),
    .seq_err(seq_err_b), .wrap(wrap_b), .locked(locked_b), .err_count(err_count_b)
  );

  typedef struct {
    logic [2:0] index;
    logic       index_vld;
    logic       onehot_err;
    logic       seq_err;
    logic       wrap;
    logic       locked;
    logic [7:0] err_a;
    logic [1:0] err_b;
  } exp_t;

  exp_t exp_q[$];

  int asserts = 0;
  int fails   = 0;

  // Reference model state
  ring_state_t m_state;
  int          m_good;
  logic [7:0]  m_prev;
  logic        m_prev_vld;
  logic [2:0]  m_index;
  logic        m_locked;
  int          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic i_init, input logic vld, input logic [7:0] d);
    exp_t e;
    logic legal, in_seq, bad;
    int   pos;
    e.index_vld = 0; e.onehot_err = 0; e.seq_err = 0; e.wrap = 0;
    if (i_init) begin
      m_state = UNLOCKED; m_good = 0; m_prev = '0; m_prev_vld = 0;
      m_index = '0; m_locked = 0; m_err = 0;
    end else if (vld) begin
      legal  = ($countones(d) == 1);
      in_seq = m_prev_vld && legal && (d == rotl1(m_prev));
      bad    = m_prev_vld && legal && !in_seq;
      pos = 0;
      for (int k = 0; k < 8; k++) if (d[k]) pos = k;
      if (legal) begin
        e.index_vld = 1;
        e.seq_err   = bad;
        e.wrap      = in_seq && m_prev[7];
        m_index     = pos[2:0];
        m_prev      = d;
        m_prev_vld  = 1;
      end else begin
        e.onehot_err = 1;
      end
      if (!legal || bad) m_err++;
      case (m_state)
        UNLOCKED: if (legal) begin m_state = ACQUIRE; m_good = 0; end
        ACQUIRE: begin
          if (!legal) begin m_state = UNLOCKED; m_good = 0; end
          else if (in_seq) begin
            m_good++;
            if (m_good == 4) begin m_state = LOCKED; m_good = 0; end
          end else m_good = 0;
        end
        default: begin
          if (!legal) m_state = UNLOCKED;
          else if (!in_seq) begin m_state = ACQUIRE; m_good = 0; end
        end
      endcase
      m_locked = (m_state == LOCKED);
    end
    e.index  = m_index;
    e.locked = m_locked;
    e.err_a  = (m_err > 255) ? 8'hFF : 8'(m_err);
    e.err_b  = (m_err > 3) ? 2'd3 : 2'(m_err);
    return e;
  endfunction

  task automatic step(input logic i_init, input logic vld, input logic [7:0] d);
    exp_t e;
    init = i_init; ring_vld = vld; ring_in = d;
    exp_q.push_back(model(i_init, vld, d));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("index",      32'(index_a),      32'(e.index));
      chk("index_vld",  32'(index_vld_a),  32'(e.index_vld));
      chk("onehot_err", 32'(onehot_err_a), 32'(e.onehot_err));
      chk("seq_err",    32'(seq_err_a),    32'(e.seq_err));
      chk("wrap",       32'(wrap_a),       32'(e.wrap));
      chk("locked",     32'(locked_a),     32'(e.locked));
      chk("err_count",  32'(err_count_a),  32'(e.err_a));
      chk("b_index",    32'(index_b),      32'(e.index));
      chk("b_locked",   32'(locked_b),     32'(e.locked));
      chk("b_seq_err",  32'(seq_err_b),    32'(e.seq_err));
      chk("b_err",      32'(err_count_b),  32'(e.err_b));
    end
  endtask

  logic [7:0] seq1 [5] = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08};
  logic [7:0] cur;

  initial begin
    // Reset, with ring_vld high and a legal code present
    step(1, 1, 8'h80);
    chk("rst_locked", 32'(locked_a), 32'd0);
    chk("rst_err",    32'(err_count_a), 32'd0);

    // 1: acquire and lock
    foreach (seq1[i]) begin
      step(0, 1, seq1[i]);
      if (i == 1) chk("t1_wrap", 32'(wrap_a), 32'd1);
    end
    chk("t1_index",  32'(index_a), 32'd3);
    chk("t1_locked", 32'(locked_a), 32'd1);
    chk("t1_err",    32'(err_count_a), 32'd0);

    // 2: illegal codes drop lock, index holds
    step(0, 1, 8'h03);
    chk("t2_locked", 32'(locked_a), 32'd0);
    chk("t2_index",  32'(index_a), 32'd3);
    chk("t2_err1",   32'(err_count_a), 32'd1);
    step(0, 1, 8'h00);
    chk("t2_err2",   32'(err_count_a), 32'd2);

    // Relock, then 3: sequence break while LOCKED
    step(0, 1, 8'h10); step(0, 1, 8'h20); step(0, 1, 8'h40);
    step(0, 1, 8'h80); step(0, 1, 8'h01); step(0, 1, 8'h02); step(0, 1, 8'h04);
    chk("t3_pre_locked", 32'(locked_a), 32'd1);
    step(0, 1, 8'h10);
    chk("t3_seq_err", 32'(seq_err_a), 32'd1);
    chk("t3_index",   32'(index_a), 32'd4);
    chk("t3_locked",  32'(locked_a), 32'd0);
    step(0, 1, 8'h20); step(0, 1, 8'h40); step(0, 1, 8'h80);
    chk("t3_not_yet", 32'(locked_a), 32'd0);
    step(0, 1, 8'h01);
    chk("t3_relock",  32'(locked_a), 32'd1);

    // 4: repeat sample and idle gaps
    step(0, 1, 8'h02);
    step(0, 0, 8'hFF); step(0, 0, 8'h04);
    chk("t4_gap_vld", 32'(index_vld_a), 32'd0);
    step(0, 1, 8'h02);
    chk("t4_repeat",  32'(seq_err_a), 32'd1);
    step(0, 0, 8'h00);

    // 5: saturation on the narrow counter
    step(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 8'hFF);
    chk("t5_b_sat",   32'(err_count_b), 32'd3);
    chk("t5_a_cnt",   32'(err_count_a), 32'd5);
    chk("t5_locked",  32'(locked_a), 32'd0);

    // 6: init while LOCKED with err_count=5
    foreach (seq1[i]) step(0, 1, seq1[i]);
    chk("t6_pre_locked", 32'(locked_a), 32'd1);
    step(1, 1, 8'h01);
    chk("t6_locked", 32'(locked_a), 32'd0);
    chk("t6_err",    32'(err_count_a), 32'd0);
    chk("t6_index",  32'(index_a), 32'd0);
    chk("t6_vld",    32'(index_vld_a), 32'd0);

    // Mixed traffic: mostly in sequence, with gaps, glitches and resets
    cur = RING_INIT;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)       step(1, $urandom_range(0, 1) == 1, cur);
      else if (r < 12) step(0, 0, 8'($urandom));
      else if (r < 20) step(0, 1, 8'($urandom));
      else if (r < 26) begin cur = 8'h01 << $urandom_range(0, 7); step(0, 1, cur); end
      else begin cur = rotl1(cur); step(0, 1, cur); end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
